// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding
// and the bit-counter width derivation.
package serial_add_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN
    } state_e;

    // A one-bit adder still needs a one-bit counter, so clamp the minimum to 1.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, reused every cycle by the serial controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Pure combinational sum and carry.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: walks one full_adder across WIDTH cycles,
// LSB first, and reports sum, carry-out and signed overflow with a done pulse.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] aSh_q, aSh_d;
    logic [WIDTH-1:0] bSh_q, bSh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             faSum;
    logic             faCout;

    full_adder u_fa (
        .a    (aSh_q[0]),
        .b    (bSh_q[0]),
        .cin  (carry_q),
        .sum  (faSum),
        .cout (faCout)
    );

    // State and datapath registers; reset discards any in-flight add.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            aSh_q   <= '0;
            bSh_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            aSh_q   <= aSh_d;
            bSh_q   <= bSh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: capture operands in IDLE, shift one bit per RUN cycle,
    // and publish the result only on the final RUN edge.
    always_comb begin
        state_d = state_q;
        aSh_d   = aSh_q;
        bSh_d   = bSh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    aSh_d   = a;
                    bSh_d   = b;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                aSh_d   = aSh_q >> 1;
                bSh_d   = bSh_q >> 1;
                res_d   = (res_q >> 1) | (WIDTH'(faSum) << (WIDTH - 1));
                carry_d = faCout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    sum_d   = res_d;
                    cout_d  = faCout;
                    ovf_d   = carry_q ^ faCout;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Drive outputs straight from registers.
    always_comb begin
        busy = (state_q == S_RUN);
        done = done_q;
        sum  = sum_q;
        cout = cout_q;
        ovf  = ovf_q;
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: an 8-bit instance for the main cases
// and a 1-bit instance swept across the full-adder truth table.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic       cin8;
    logic [0:0] a1, b1;
    logic       cin1;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
    logic       busy1, done1, cout1, ovf1;
    logic [0:0] sum1;

    int total = 0;
    int bad   = 0;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Launch one 8-bit add and wait for done; lat counts negedges after the
    // accepting edge, busyCycles counts busy samples before done.
    task automatic runAdd8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                           output int lat, output int busyCycles);
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0; busyCycles = 0;
        while (!done8 && lat < 30) begin
            if (busy8) busyCycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done8); end
        total++; if (sum8 !== 8'h00) begin bad++; $display("[TB] FAIL reset_sum got=%h want=00", sum8); end
        total++; if (cout8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_cout got=%b want=0", cout8); end
        total++; if (ovf8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%b want=0", ovf8); end
        total++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_w1 got busy=%b done=%b want 0 0", busy1, done1); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, bc;
        runAdd8(8'h5A, 8'h33, 1'b0, lat, bc);
        total++; if (lat != 8) begin bad++; $display("[TB] FAIL basic_latency got=%0d want=8", lat); end
        total++; if (bc != 8) begin bad++; $display("[TB] FAIL basic_busy_cycles got=%0d want=8", bc); end
        total++; if (busy8 !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_at_done got=%b want=0", busy8); end
        total++; if (sum8 !== 8'h8D) begin bad++; $display("[TB] FAIL basic_sum got=%h want=8d", sum8); end
        total++; if (cout8 !== 1'b0) begin bad++; $display("[TB] FAIL basic_cout got=%b want=0", cout8); end
        total++; if (ovf8 !== 1'b1) begin bad++; $display("[TB] FAIL basic_ovf got=%b want=1", ovf8); end
        @(negedge clk);
        total++; if (done8 !== 1'b0) begin bad++; $display("[TB] FAIL basic_done_pulse got=%b want=0", done8); end
    endtask

    task automatic test_carry();
        int lat, bc;
        runAdd8(8'hFF, 8'h01, 1'b0, lat, bc);
        total++; if (sum8 !== 8'h00 || cout8 !== 1'b1 || ovf8 !== 1'b0) begin
            bad++; $display("[TB] FAIL carry_wrap got sum=%h cout=%b ovf=%b want 00 1 0", sum8, cout8, ovf8);
        end
        runAdd8(8'h7F, 8'h00, 1'b1, lat, bc);
        total++; if (sum8 !== 8'h80 || cout8 !== 1'b0 || ovf8 !== 1'b1) begin
            bad++; $display("[TB] FAIL carry_cin_ovf got sum=%h cout=%b ovf=%b want 80 0 1", sum8, cout8, ovf8);
        end
    endtask

    task automatic test_ignore_start();
        int e;
        int dones;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dones = 0;
        for (e = 0; e < 20; e++) begin
            if (e == 2) begin a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1; end
            if (e == 3) start8 = 1'b0;
            if (e > 0 && e < 8) begin
                total++; if (sum8 !== 8'h80) begin bad++; $display("[TB] FAIL ignore_sum_hold e=%0d got=%h want=80", e, sum8); end
            end
            if (done8) begin
                dones++;
                total++; if (e != 8) begin bad++; $display("[TB] FAIL ignore_done_time got=%0d want=8", e); end
            end
            @(negedge clk);
        end
        total++; if (dones != 1) begin bad++; $display("[TB] FAIL ignore_done_count got=%0d want=1", dones); end
        total++; if (sum8 !== 8'h30 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
            bad++; $display("[TB] FAIL ignore_result got sum=%h cout=%b ovf=%b want 30 0 0", sum8, cout8, ovf8);
        end
        total++; if (busy8 !== 1'b0) begin bad++; $display("[TB] FAIL ignore_not_queued got busy=%b want=0", busy8); end
    endtask

    task automatic test_reset_mid();
        int e;
        int dones;
        int lat, bc;
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy8 !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy got=%b want=0", busy8); end
        total++; if (sum8 !== 8'h00) begin bad++; $display("[TB] FAIL rstmid_sum got=%h want=00", sum8); end
        dones = 0;
        for (e = 0; e < 12; e++) begin
            if (done8) dones++;
            @(negedge clk);
        end
        total++; if (dones != 0) begin bad++; $display("[TB] FAIL rstmid_no_done got=%0d want=0", dones); end
        runAdd8(8'h01, 8'h01, 1'b0, lat, bc);
        total++; if (lat != 8 || sum8 !== 8'h02) begin
            bad++; $display("[TB] FAIL rstmid_restart got lat=%0d sum=%h want 8 02", lat, sum8);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        int dones;
        int prevDone;
        int w;
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        dones = 0; prevDone = -1;
        for (e = 0; e < 40; e++) begin
            if (done8) begin
                dones++;
                if (prevDone >= 0) begin
                    total++; if (e - prevDone != 9) begin bad++; $display("[TB] FAIL b2b_spacing got=%0d want=9", e - prevDone); end
                end else begin
                    total++; if (e != 8) begin bad++; $display("[TB] FAIL b2b_first_done got=%0d want=8", e); end
                end
                prevDone = e;
            end
            if (dones > 0) begin
                total++; if (sum8 !== 8'h07) begin bad++; $display("[TB] FAIL b2b_sum e=%0d got=%h want=07", e, sum8); end
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        total++; if (dones != 4) begin bad++; $display("[TB] FAIL b2b_done_count got=%0d want=4", dones); end
        w = 0;
        while (busy8 && w < 20) begin @(negedge clk); w++; end
        total++; if (busy8 !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drain got busy=%b want=0", busy8); end
        @(negedge clk);
    endtask

    task automatic test_width1();
        logic [2:0] v;
        logic [1:0] expSum;
        int lat;
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            expSum = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
            @(negedge clk);
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            lat = 0;
            while (!done1 && lat < 10) begin @(negedge clk); lat++; end
            total++; if (lat != 1) begin bad++; $display("[TB] FAIL w1_latency v=%0d got=%0d want=1", i, lat); end
            total++; if ({cout1, sum1} !== expSum) begin
                bad++; $display("[TB] FAIL w1_sum v=%0d got=%b%b want=%b", i, cout1, sum1, expSum);
            end
            total++; if (ovf1 !== (v[0] ^ expSum[1])) begin
                bad++; $display("[TB] FAIL w1_ovf v=%0d got=%b want=%b", i, ovf1, v[0] ^ expSum[1]);
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_width1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: sequences a single existing full_adder cell over WIDTH clock cycles to add two WIDTH-bit operands, LSB first.
- Accepts a start request, captures the operands, and steps the carry through a register.
- Reports the sum, carry-out and signed overflow with a one-cycle done pulse.
- Sits between a requesting FSM/testbench and the shared full_adder datapath; it is the area-minimal alternative to a ripple array.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1.
- CNT_W, $clog2(WIDTH) (1 when WIDTH==1), width of the internal bit counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result, held until the next completion.
- cout  output  1  registered unsigned carry-out.
- ovf  output  1  registered signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
  - Counter, shift registers and carry register cleared.
  - Reset overrides everything, including mid-operation: the in-flight add is discarded and done does not pulse.
- States:
  - IDLE: busy=0. If start=1 at an edge, go to RUN. On that edge, capture a and b into shift registers, carry_q=cin, cnt=0, busy=1.
  - RUN: busy=1. Each edge feeds a_sh[0], b_sh[0] and carry_q into the full_adder instance. On that edge:
    - the fa sum bit shifts into the result shift register from the MSB side;
    - a_sh and b_sh shift right by one;
    - carry_q takes fa cout;
    - cnt increments.
  - Last RUN edge (cnt==WIDTH-1):
    - go to IDLE; busy=0; done=1 for exactly one cycle;
    - sum is loaded with the final shifted result;
    - cout = fa cout;
    - ovf = carry_q (carry into MSB) XOR fa cout.
- Latency: start accepted at edge k; done, sum, cout and ovf are visible after edge k+WIDTH; busy is high for cycles k+1..k+WIDTH inclusive.
- Throughput: a start at edge k+WIDTH+1 (the cycle done is high) is accepted. Back-to-back adds therefore run with one idle edge each, giving WIDTH+1 cycles per add.
- start while busy=1 is ignored: not queued, and operands are not re-captured.
- a, b and cin may change freely after capture without affecting the result.
- sum, cout and ovf never change during RUN; they update only on the completing edge.
- WIDTH==1: a single RUN edge. done appears one edge after start. ovf = cin XOR cout.
- Carry wrap-around: the sum is modulo 2^WIDTH and the overflow carry is reported only on cout.

Decomposition:
- Shared package serial_add_pkg holds:
  - state encoding localparams ST_IDLE=1'b0 and ST_RUN=1'b1;
  - the CNT_W derivation function.
- One sub-module: full_adder (existing cell, ports a, b, cin, sum, cout), instantiated once as the combinational datapath. No other sub-modules.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, cin=0, start pulse -> done after 8 edges; sum=0x8D, cout=0, ovf=1; busy high exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- Start a=0x10, b=0x20; pulse start again at edge 3 with a=0xFF, b=0xFF -> second start ignored; sum=0x30, single done pulse.
- Start a=0xAA, b=0x55; assert rst at edge 4 -> busy=0 and sum=0 next cycle; no done. New start a=0x01, b=0x01 -> sum=0x02.
- Back-to-back: start held high continuously with a=0x03, b=0x04 -> done every 9 edges; sum=0x07 each time; sum stable between pulses.
- WIDTH=1 instance: sweep {a,b,cin}=0..7 one add each -> {cout,sum} matches the full-adder truth table; done 1 edge after each start.
